// File: rtl/v_dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// access-owner encoding and default bus widths.
package v_dmem_arbiter_pkg;

    localparam int unsigned DEF_AW = 8;
    localparam int unsigned DEF_DW = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

endpackage

// File: rtl/v_dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU memory stage, debug/loader), the
// arbiter and the single-port data memory. slave = arbiter side.
interface v_dmem_arbiter_if
    import v_dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) ();

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/v_dmem_arb_pick.sv
// Combinational winner select between the CPU and debug requests. On a tie the
// port not granted last wins; the top feeds a constant DBG for fixed CPU priority.
module v_dmem_arb_pick
    import v_dmem_arbiter_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dbg_req,
    input  owner_e last_grant,
    output logic   any_req,
    output owner_e grant
);

    always_comb begin
        any_req = cpu_req | dbg_req;
        grant   = OWN_CPU;
        if (cpu_req && dbg_req) begin
            grant = (last_grant == OWN_CPU) ? OWN_DBG : OWN_CPU;
        end else if (dbg_req) begin
            grant = OWN_DBG;
        end
    end

endmodule

// File: rtl/v_dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: IDLE -> ISSUE -> RESP per access.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module v_dmem_arbiter
    import v_dmem_arbiter_pkg::*;
(
    input logic             clk,
    input logic             rst,
    v_dmem_arbiter_if.slave bus
);

    state_e              state_q, state_d;
    owner_e              owner_q;
    owner_e              grant;
    owner_e              last_grant;
    logic                any_req;
    logic                take;
    logic                we_q;
    logic [DEF_AW-1:0]   addr_q;
    logic [DEF_DW-1:0]   wdata_q;
    logic [DEF_DW-1:0]   cpu_rdata_q;
    logic [DEF_DW-1:0]   dbg_rdata_q;

    v_dmem_arb_pick u_pick (
        .cpu_req    (bus.cpu_req),
        .dbg_req    (bus.dbg_req),
        .last_grant (last_grant),
        .any_req    (any_req),
        .grant      (grant)
    );

    assign take = (state_q == StIdle) && any_req;

`ifdef DMEM_ARB_RR_EN
    owner_e last_grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= OWN_DBG;
        end else if (take) begin
            last_grant_q <= grant;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = OWN_DBG;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StIssue;
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Winner's command is frozen here so the memory sees it stable through ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            owner_q <= grant;
            if (grant == OWN_CPU) begin
                we_q    <= bus.cpu_we;
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
            end else begin
                we_q    <= bus.dbg_we;
                addr_q  <= bus.dbg_addr;
                wdata_q <= bus.dbg_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else if ((state_q == StIssue) && !we_q) begin
            if (owner_q == OWN_CPU) begin
                cpu_rdata_q <= bus.mem_rdata;
            end else begin
                dbg_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = (state_q == StIssue);
    assign bus.mem_we    = (state_q == StIssue) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.cpu_ack   = (state_q == StResp) && (owner_q == OWN_CPU);
    assign bus.dbg_ack   = (state_q == StResp) && (owner_q == OWN_DBG);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;

endmodule

// File: tb/tb_v_dmem_arbiter.sv
// Self-checking bench for v_dmem_arbiter with a transaction-level reference model.
// Build with DMEM_ARB_RR_EN defined to check round-robin arbitration.
module tb_v_dmem_arbiter;
    import v_dmem_arbiter_pkg::*;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] exp_cpu_rd;
    logic [31:0] exp_dbg_rd;
    int          last_port;  // 0 = CPU, 1 = DBG

    v_dmem_arbiter_if bus ();

    v_dmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata = mem[bus.mem_addr];

    // Reference policy: tie goes to the port not granted last (RR) or always to CPU.
    function automatic int pick_ref(input bit c, input bit d);
        if (c && d) return RR ? ((last_port == 0) ? 1 : 0) : 0;
        return c ? 0 : 1;
    endfunction

    // Apply one completed access to the model; rd = owner's rdata as seen at ack.
    task automatic model_op(input int p, input bit we, input logic [7:0] a,
                            input logic [31:0] wd, output logic [31:0] rd);
        if (we) ref_mem[a] = wd;
        else if (p == 0) exp_cpu_rd = ref_mem[a];
        else exp_dbg_rd = ref_mem[a];
        rd = (p == 0) ? exp_cpu_rd : exp_dbg_rd;
        last_port = p;
    endtask

    task automatic model_reset();
        exp_cpu_rd = '0;
        exp_dbg_rd = '0;
        last_port  = 1;
    endtask

    // Drive up to one request per port, drop each on its ack; -1 latency = never acked.
    task automatic run_ops(input bit c_en, input bit c_we, input logic [7:0] c_a,
                           input logic [31:0] c_wd, input bit d_en, input bit d_we,
                           input logic [7:0] d_a, input logic [31:0] d_wd,
                           output int c_lat, output int d_lat, output logic [31:0] c_rd,
                           output logic [31:0] d_rd, output int c_stall);
        bit c_done, d_done;
        c_lat = -1; d_lat = -1; c_rd = '0; d_rd = '0; c_stall = 0;
        @(negedge clk);
        bus.cpu_req = c_en; bus.cpu_we = c_we; bus.cpu_addr = c_a; bus.cpu_wdata = c_wd;
        bus.dbg_req = d_en; bus.dbg_we = d_we; bus.dbg_addr = d_a; bus.dbg_wdata = d_wd;
        c_done = !c_en;
        d_done = !d_en;
        for (int k = 0; k < 20 && !(c_done && d_done); k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (bus.cpu_stall) c_stall++;
            if (bus.cpu_ack && !c_done) begin
                c_lat = k; c_rd = bus.cpu_rdata; c_done = 1'b1; bus.cpu_req = 1'b0;
            end
            if (bus.dbg_ack && !d_done) begin
                d_lat = k; d_rd = bus.dbg_rdata; d_done = 1'b1; bus.dbg_req = 1'b0;
            end
        end
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
    endtask

    task automatic test_reset();
        int cl, dl, cs;
        logic [31:0] crd, drd, rd;
        #1;
        total++; if (bus.mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%0b want=0", bus.mem_en); end
        total++; if (bus.cpu_ack !== 1'b0 || bus.dbg_ack !== 1'b0) begin
            bad++; $display("FAIL rst_acks got=%0b%0b want=00", bus.cpu_ack, bus.dbg_ack);
        end
        @(negedge clk);
        rst = 1'b0;
        run_ops(1, 1, 8'h55, 32'hA5A5_0F0F, 0, 0, 8'h0, 32'h0, cl, dl, crd, drd, cs);
        model_op(0, 1, 8'h55, 32'hA5A5_0F0F, rd);
        run_ops(1, 0, 8'h55, 32'h0, 0, 0, 8'h0, 32'h0, cl, dl, crd, drd, cs);
        model_op(0, 0, 8'h55, 32'h0, rd);
        total++; if (crd !== rd) begin bad++; $display("FAIL rst_pre_read got=%h want=%h", crd, rd); end
        // Start a debug write and pull reset in the middle of its ISSUE cycle.
        @(negedge clk);
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h66; bus.dbg_wdata = 32'h1234_5678;
        @(negedge clk);
        #1;
        total++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) begin
            bad++; $display("FAIL rst_issue_setup en=%0b we=%0b want=11", bus.mem_en, bus.mem_we);
        end
        rst = 1'b1;
        bus.dbg_req = 1'b0;
        #1;
        model_reset();
        total++; if ({bus.mem_en, bus.mem_we, bus.cpu_ack, bus.dbg_ack, bus.cpu_stall} !== 5'b0) begin
            bad++; $display("FAIL rst_async_ctrl got=%b want=00000",
                            {bus.mem_en, bus.mem_we, bus.cpu_ack, bus.dbg_ack, bus.cpu_stall});
        end
        total++; if (bus.mem_addr !== 8'h0 || bus.mem_wdata !== 32'h0) begin
            bad++; $display("FAIL rst_async_mem addr=%h wdata=%h want=0", bus.mem_addr, bus.mem_wdata);
        end
        total++; if (bus.cpu_rdata !== exp_cpu_rd || bus.dbg_rdata !== exp_dbg_rd) begin
            bad++; $display("FAIL rst_rdata cpu=%h dbg=%h want=0", bus.cpu_rdata, bus.dbg_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            total++; if (bus.cpu_ack !== 1'b0 || bus.dbg_ack !== 1'b0 || bus.mem_en !== 1'b0) begin
                bad++; $display("FAIL rst_quiet k=%0d acks=%0b%0b en=%0b want=0", k,
                                bus.cpu_ack, bus.dbg_ack, bus.mem_en);
            end
        end
    endtask

    task automatic test_cpu_write_read();
        int cl, dl, cs;
        logic [31:0] crd, drd, rd;
        run_ops(1, 1, 8'h10, 32'hDEAD_BEEF, 0, 0, 8'h0, 32'h0, cl, dl, crd, drd, cs);
        model_op(0, 1, 8'h10, 32'hDEAD_BEEF, rd);
        total++; if (cl !== 2) begin bad++; $display("FAIL cpu_wr_lat got=%0d want=2", cl); end
        total++; if (cs !== 2) begin bad++; $display("FAIL cpu_wr_stall got=%0d want=2", cs); end
        run_ops(1, 0, 8'h10, 32'h0, 0, 0, 8'h0, 32'h0, cl, dl, crd, drd, cs);
        model_op(0, 0, 8'h10, 32'h0, rd);
        total++; if (cl !== 2) begin bad++; $display("FAIL cpu_rd_lat got=%0d want=2", cl); end
        total++; if (cs !== 2) begin bad++; $display("FAIL cpu_rd_stall got=%0d want=2", cs); end
        total++; if (crd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cpu_rd_data got=%h want=deadbeef", crd); end
    endtask

    task automatic test_dbg_load();
        int ack_cyc[4];
        int n = 0;
        int k0;
        int cl, dl, cs;
        logic [31:0] crd, drd, rd;
        for (int i = 0; i < 4; i++) ack_cyc[i] = -100;
        @(negedge clk);
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h00; bus.dbg_wdata = 32'd1;
        k0 = cyc;
        for (int k = 0; k < 30 && n < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (bus.dbg_ack) begin
                ack_cyc[n] = cyc;
                model_op(1, 1, 8'(n), 32'(n + 1), rd);
                n++;
                if (n < 4) begin bus.dbg_addr = 8'(n); bus.dbg_wdata = 32'(n + 1); end
                else bus.dbg_req = 1'b0;
            end
        end
        bus.dbg_req = 1'b0;
        total++; if (n !== 4) begin bad++; $display("FAIL dbg_load_count got=%0d want=4", n); end
        total++; if (ack_cyc[0] - k0 !== 2) begin
            bad++; $display("FAIL dbg_load_first got=%0d want=2", ack_cyc[0] - k0);
        end
        for (int i = 1; i < 4; i++) begin
            total++; if (ack_cyc[i] - ack_cyc[i-1] !== 3) begin
                bad++; $display("FAIL dbg_load_gap%0d got=%0d want=3", i, ack_cyc[i] - ack_cyc[i-1]);
            end
        end
        run_ops(1, 0, 8'h02, 32'h0, 0, 0, 8'h0, 32'h0, cl, dl, crd, drd, cs);
        model_op(0, 0, 8'h02, 32'h0, rd);
        total++; if (crd !== 32'd3) begin bad++; $display("FAIL dbg_load_readback got=%h want=3", crd); end
    endtask

    task automatic test_collision();
        int cl, dl, cs, w;
        logic [31:0] crd, drd, rd_c, rd_d, cwd, dwd;
        bit cwe, dwe;
        for (int it = 0; it < 4; it++) begin
            cwe = (it == 0) ? 1'b1 : 1'($urandom);
            dwe = (it == 0) ? 1'b1 : 1'($urandom);
            cwd = $urandom;
            dwd = $urandom;
            w = pick_ref(1, 1);
            run_ops(1, cwe, 8'h20, cwd, 1, dwe, 8'h21, dwd, cl, dl, crd, drd, cs);
            if (w == 0) begin
                model_op(0, cwe, 8'h20, cwd, rd_c); model_op(1, dwe, 8'h21, dwd, rd_d);
            end else begin
                model_op(1, dwe, 8'h21, dwd, rd_d); model_op(0, cwe, 8'h20, cwd, rd_c);
            end
            total++; if (cl !== ((w == 0) ? 2 : 5)) begin
                bad++; $display("FAIL coll%0d_cpu_lat got=%0d want=%0d", it, cl, (w == 0) ? 2 : 5);
            end
            total++; if (dl !== ((w == 1) ? 2 : 5)) begin
                bad++; $display("FAIL coll%0d_dbg_lat got=%0d want=%0d", it, dl, (w == 1) ? 2 : 5);
            end
            total++; if (crd !== rd_c || drd !== rd_d) begin
                bad++; $display("FAIL coll%0d_rdata cpu=%h/%h dbg=%h/%h", it, crd, rd_c, drd, rd_d);
            end
        end
    endtask

    task automatic test_held_both();
        int exp_w[4];
        int got_w[4];
        int ack_cyc[4];
        int n = 0;
        int ci = 0;
        int di = 0;
        logic [31:0] rd;
        for (int i = 0; i < 4; i++) begin
            exp_w[i] = pick_ref(1, 1);
            last_port = exp_w[i];
            got_w[i] = -1;
            ack_cyc[i] = -100;
        end
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h80; bus.cpu_wdata = $urandom;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h90; bus.dbg_wdata = $urandom;
        for (int k = 0; k < 40 && n < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (bus.cpu_ack) begin
                model_op(0, 1, bus.cpu_addr, bus.cpu_wdata, rd);
                got_w[n] = 0; ack_cyc[n] = cyc; n++; ci++;
                bus.cpu_addr = 8'h80 + 8'(ci); bus.cpu_wdata = $urandom;
            end
            if (bus.dbg_ack) begin
                model_op(1, 1, bus.dbg_addr, bus.dbg_wdata, rd);
                got_w[n] = 1; ack_cyc[n] = cyc; n++; di++;
                bus.dbg_addr = 8'h90 + 8'(di); bus.dbg_wdata = $urandom;
            end
            if (n >= 4) begin bus.cpu_req = 1'b0; bus.dbg_req = 1'b0; end
        end
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (got_w[i] !== exp_w[i]) begin
                bad++; $display("FAIL held_grant%0d got=%0d want=%0d", i, got_w[i], exp_w[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            total++; if (ack_cyc[i] - ack_cyc[i-1] !== 3) begin
                bad++; $display("FAIL held_gap%0d got=%0d want=3", i, ack_cyc[i] - ack_cyc[i-1]);
            end
        end
    endtask

    task automatic test_random();
        int cl, dl, cs, w, m;
        logic [31:0] crd, drd, rd_c, rd_d, cwd, dwd;
        logic [7:0] ca, da;
        bit cwe, dwe, cen, den;
        for (int i = 0; i < 8; i++) begin
            cwd = $urandom;
            run_ops(1, 1, 8'h40 + 8'(i), cwd, 0, 0, 8'h0, 32'h0, cl, dl, crd, drd, cs);
            model_op(0, 1, 8'h40 + 8'(i), cwd, rd_c);
        end
        for (int it = 0; it < 30; it++) begin
            m = $urandom_range(0, 2);
            cen = (m != 1); den = (m != 0);
            cwe = 1'($urandom); dwe = 1'($urandom);
            ca = 8'h40 + 8'($urandom_range(0, 7)); da = 8'h40 + 8'($urandom_range(0, 7));
            cwd = $urandom; dwd = $urandom;
            w = pick_ref(cen, den);
            run_ops(cen, cwe, ca, cwd, den, dwe, da, dwd, cl, dl, crd, drd, cs);
            rd_c = '0; rd_d = '0;
            if (w == 0) begin
                if (cen) model_op(0, cwe, ca, cwd, rd_c);
                if (den) model_op(1, dwe, da, dwd, rd_d);
            end else begin
                if (den) model_op(1, dwe, da, dwd, rd_d);
                if (cen) model_op(0, cwe, ca, cwd, rd_c);
            end
            total++; if (cl !== (!cen ? -1 : (w == 0) ? 2 : 5) || cs !== (!cen ? 0 : cl)) begin
                bad++; $display("FAIL rnd%0d_cpu lat=%0d stall=%0d en=%0b win=%0d", it, cl, cs, cen, w);
            end
            total++; if (dl !== (!den ? -1 : (w == 1) ? 2 : 5)) begin
                bad++; $display("FAIL rnd%0d_dbg lat=%0d en=%0b win=%0d", it, dl, den, w);
            end
            total++; if (crd !== rd_c || drd !== rd_d) begin
                bad++; $display("FAIL rnd%0d_ack_rdata cpu=%h/%h dbg=%h/%h", it, crd, rd_c, drd, rd_d);
            end
            total++; if (bus.cpu_rdata !== exp_cpu_rd || bus.dbg_rdata !== exp_dbg_rd) begin
                bad++; $display("FAIL rnd%0d_hold_rdata cpu=%h/%h dbg=%h/%h", it, bus.cpu_rdata,
                                exp_cpu_rd, bus.dbg_rdata, exp_dbg_rd);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_issue();
        int cl, dl, cs;
        logic [31:0] crd, drd, rd;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h30; bus.cpu_wdata = 32'hCAFE_0001;
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            total++; if (bus.cpu_ack !== 1'b0) begin bad++; $display("FAIL rsti_ack_in_rst k=%0d got=1 want=0", k); end
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            total++; if (bus.cpu_ack !== 1'b0) begin bad++; $display("FAIL rsti_ack_after k=%0d got=1 want=0", k); end
        end
        run_ops(1, 1, 8'h30, 32'hCAFE_0002, 0, 0, 8'h0, 32'h0, cl, dl, crd, drd, cs);
        model_op(0, 1, 8'h30, 32'hCAFE_0002, rd);
        total++; if (cl !== 2) begin bad++; $display("FAIL rsti_retry_lat got=%0d want=2", cl); end
        run_ops(1, 0, 8'h30, 32'h0, 0, 0, 8'h0, 32'h0, cl, dl, crd, drd, cs);
        model_op(0, 0, 8'h30, 32'h0, rd);
        total++; if (crd !== rd) begin bad++; $display("FAIL rsti_readback got=%h want=%h", crd, rd); end
    endtask

    initial begin
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_cpu_write_read();
        test_dbg_load();
        test_collision();
        test_held_both();
        test_random();
        test_reset_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/v_dmem_arbiter.md
# v_dmem_arbiter

Shares the single-port 256x32 data memory between the pipeline's memory stage (CPU port) and the debug/loader port. Accepts held-request/ack transactions from both, sequences each into a one-access memory cycle through a three-state FSM, returns read data and ack, and stalls the pipeline while the CPU access is outstanding. Sits between the memory stage and the data memory array.

## Interface
- AW, 8, memory word-address width (256 words)
- DW, 32, data width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write (SW), 0 = read (LW)
- cpu_addr  in  AW  word address
- cpu_wdata  in  DW  write data
- cpu_rdata  out  DW  read data, valid while cpu_ack=1 on a read
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack, combinational, to pipeline hazard logic
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug port, same rules as CPU
- dbg_rdata  out  DW;  dbg_ack  out  1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable (write committed at edge ending ISSUE)
- mem_addr  out  AW;  mem_wdata  out  DW
- mem_rdata  in  DW  asynchronous read data for mem_addr

## Operation
- FSM states: IDLE, ISSUE, RESP. Transitions: IDLE->ISSUE when any req=1; ISSUE->RESP always; RESP->IDLE always.
- IDLE: pick winner, latch owner, we, addr, wdata into internal registers at the edge.
- ISSUE: mem_en=1, mem_we/addr/wdata from latched registers; on a read, mem_rdata captured into owner's rdata register at end of cycle; non-owner rdata register unchanged.
- RESP: owner's ack=1 for exactly one cycle; rdata register holds value until next read by that owner.
- Request is consumed by ack; req still high in the cycle after ack is a new request. Requester must keep we/addr/wdata stable from req rise until ack.
- Default arbitration: fixed priority, CPU wins over debug; debug may starve under continuous CPU traffic (accepted).
- Non-owner request is held pending; no timeout, no error.

## Timing
- Reset values: state=IDLE, all acks 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rdata 0, dbg_rdata 0, last_grant=DBG.
- Latency: req seen in IDLE cycle t -> ISSUE t+1 -> ack in t+2. Throughput one access per 3 cycles.
- cpu_stall high in t, t+1; low in t+2.
- Simultaneous cpu_req and dbg_req in IDLE: arbitration rule decides; loser served next round (t+3).
- rst asserted mid-ISSUE: mem_en/mem_we drop immediately (asynchronous), write not guaranteed committed; no ack issued for the aborted access.
- Address has no range check; wraps at AW bits.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin; on simultaneous requests the port not granted last wins; last_grant updated on every grant.
- Undefined: fixed CPU priority; last_grant register absent.

## Structure
- Shared package: FSM state encoding (IDLE/ISSUE/RESP), owner encoding (OWN_CPU, OWN_DBG), default AW/DW constants.
- One sub-module: v_dmem_arb_pick (combinational winner select from two reqs plus last_grant), so the priority policy is swappable by macro.

## Test plan
- Reset: rst=1 mid-run -> all outputs 0, state IDLE within the same cycle; no ack after release without a req.
- CPU write then read: write addr 8'h10 data 32'hDEADBEEF, then read 8'h10 -> cpu_ack at t+2 each, cpu_rdata=32'hDEADBEEF, cpu_stall high exactly 2 cycles per access.
- Debug load: dbg writes 8'h00..8'h03 with 1,2,3,4 back-to-back (req held) -> 4 acks spaced 3 cycles; CPU read of 8'h02 returns 3.
- Collision, macro off: both req in same cycle, CPU addr 8'h20, dbg addr 8'h21 -> CPU ack at t+2, dbg ack at t+5.
- Collision, DMEM_ARB_RR_EN on, both held continuously -> grants alternate CPU, DBG, CPU, DBG; neither port waits more than 6 cycles.
- Reset during ISSUE of a CPU write to 8'h30 -> no cpu_ack; after release, cpu_req again completes normally with ack at t+2.
